// File: rtl/fetch_unit.sv
// fetch_unit: owns fetch PC, issues ICache INCR bursts, queues beats for decode; FETCH_PERF_EN adds perf counters
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BURST_LEN = 4,
  parameter int          FQ_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        arvalid,
  output logic [31:0] araddr,
  output logic [1:0]  arburst,
  output logic [2:0]  arsize,
  output logic [7:0]  arlen,
  input  logic        arready,
  input  logic        rvalid,
  input  logic [63:0] rdata,
  input  logic        rlast,
  output logic        rready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [63:0] out_instr,
  output logic [1:0]  out_mask
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_beats,
  output logic [31:0] perf_flushes
`endif
);
  localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CW = $clog2(FQ_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;
  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d, araddr_q, araddr_d, beat_pc_q, beat_pc_d, tgt_pc_q, tgt_pc_d;
  logic [7:0]    arlen_q, arlen_d, len_nxt;
  logic [CW-1:0] cnt_q, cnt_d, res_q, res_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic          drain_q, drain_d, tgt_pend_q, tgt_pend_d, tgt_half_q, tgt_half_d;
  logic          push, pop;
  logic [31:0]   free, idx;
  logic [1:0]    push_mask;
  logic [31:0]   fq_pc [FQ_DEPTH];
  logic [63:0]   fq_instr [FQ_DEPTH];
  logic [1:0]    fq_mask [FQ_DEPTH];

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(FQ_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Next state: burst sizing, space reservation, queue pointers, redirect flush
  always_comb begin
    idx = (fetch_pc_q >> 3) & 32'(BURST_LEN - 1);
    len_nxt = 8'(32'(BURST_LEN) - 32'd1 - idx);
    free = 32'(FQ_DEPTH) - 32'(cnt_q) - 32'(res_q);
    push = (state_q == DATA) && rvalid && !redirect_valid;
    pop = out_valid && out_ready;
    push_mask = (tgt_pend_q && tgt_half_q && beat_pc_q == tgt_pc_q) ? 2'b10 : 2'b11;
    state_d = state_q;
    fetch_pc_d = fetch_pc_q;
    araddr_d = araddr_q;
    arlen_d = arlen_q;
    beat_pc_d = beat_pc_q;
    res_d = res_q;
    wr_d = wr_q;
    rd_d = rd_q;
    drain_d = drain_q;
    tgt_pend_d = tgt_pend_q;
    tgt_pc_d = tgt_pc_q;
    tgt_half_d = tgt_half_q;
    case (state_q)
      IDLE: begin
        if (!redirect_valid && free >= 32'(len_nxt) + 32'd1) begin
          state_d = ADDR;
          araddr_d = fetch_pc_q;
          arlen_d = len_nxt;
        end
      end
      ADDR: begin
        if (arready) begin
          state_d = (drain_q || redirect_valid) ? DRAIN : DATA;
          drain_d = 1'b0;
          beat_pc_d = araddr_q;
          if (!drain_q) begin
            fetch_pc_d = araddr_q + ((32'(arlen_q) + 32'd1) << 3);
            res_d = res_q + CW'(arlen_q) + CW'(1);
          end
        end else if (redirect_valid) begin
          drain_d = 1'b1;
        end
      end
      default: state_d = (rvalid && rlast) ? IDLE : (redirect_valid ? DRAIN : state_q);
    endcase
    if (push) begin
      beat_pc_d = beat_pc_q + 32'd8;
      res_d = res_q - CW'(1);
      wr_d = inc(wr_q);
      if (beat_pc_q == tgt_pc_q) tgt_pend_d = 1'b0;
    end
    if (pop) rd_d = inc(rd_q);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~32'h7;
      tgt_pc_d = redirect_pc & ~32'h7;
      tgt_half_d = redirect_pc[2];
      tgt_pend_d = 1'b1;
      res_d = '0;
      cnt_d = '0;
      wr_d = '0;
      rd_d = '0;
    end
  end

  // State and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fetch_pc_q <= RESET_PC;
      araddr_q <= RESET_PC;
      arlen_q <= '0;
      beat_pc_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      drain_q <= 1'b0;
      tgt_pend_q <= 1'b0;
      tgt_pc_q <= '0;
      tgt_half_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      araddr_q <= araddr_d;
      arlen_q <= arlen_d;
      beat_pc_q <= beat_pc_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      drain_q <= drain_d;
      tgt_pend_q <= tgt_pend_d;
      tgt_pc_q <= tgt_pc_d;
      tgt_half_q <= tgt_half_d;
    end
  end

  // Fetch-queue storage; occupancy is tracked by the pointers above
  always_ff @(posedge clk) begin
    if (push) begin
      fq_pc[wr_q] <= beat_pc_q;
      fq_instr[wr_q] <= rdata;
      fq_mask[wr_q] <= push_mask;
    end
  end

  assign arvalid = (state_q == ADDR);
  assign araddr = araddr_q;
  assign arlen = arlen_q;
  assign arburst = 2'b01;
  assign arsize = 3'b011;
  assign rready = (state_q == DATA) || (state_q == DRAIN);
  assign out_valid = (cnt_q != '0) && !redirect_valid;
  assign out_pc = fq_pc[rd_q];
  assign out_instr = fq_instr[rd_q];
  assign out_mask = fq_mask[rd_q];

`ifdef FETCH_PERF_EN
  logic [31:0] perf_beats_q, perf_beats_d, perf_flushes_q, perf_flushes_d;
  // Count beats pushed into the queue and redirect pulses
  always_comb begin
    perf_beats_d = perf_beats_q + 32'(push);
    perf_flushes_d = perf_flushes_q + 32'(redirect_valid);
  end
  // Perf counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_beats_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      perf_beats_q <= perf_beats_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end
  assign perf_beats = perf_beats_q;
  assign perf_flushes = perf_flushes_q;
`endif
endmodule
